// File: rtl/ah_client_dispatch_24.sv
// ah_client_dispatch_24: one-deep registered dispatch stage.
// Presents a decoded packet to a single client and drops bad or stale ones.
module ah_client_dispatch_24 #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      ingress_pkt_field,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [NUM_CLIENTS-1:0] decoded_binary,
    input  logic                   dec_err,
    output logic [NUM_CLIENTS-1:0] out_valid,
    input  logic [NUM_CLIENTS-1:0] out_ready,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [DATA_W-1:0]      out_data,
    output logic                   err_pulse,
    output logic                   timeout_pulse,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [CNT_W-1:0]       timeout_cnt
);

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      data_q;
    logic [NUM_CLIENTS-1:0] sel_q;
    logic [WAIT_W-1:0]      wait_cnt;
    logic                   err_pulse_q;
    logic                   tmo_pulse_q;
    logic [CNT_W-1:0]       err_cnt_q;
    logic [CNT_W-1:0]       tmo_cnt_q;

    logic holding;
    logic done;
    logic tmo;
    logic multi_hot;
    logic bad;
    logic accept;
    logic good_acc;
    logic bad_acc;

    assign holding = (state_q == HOLD);
    assign done    = holding && (|(sel_q & out_ready));
    assign tmo     = (TIMEOUT != 0) && holding && !done
                     && (wait_cnt == WAIT_MAX);

    // x & (x-1) clears the lowest set bit; anything left means multi-hot
    assign multi_hot = |(decoded_binary
                         & (decoded_binary - NUM_CLIENTS'(1)));
    assign bad       = dec_err || (decoded_binary == '0) || multi_hot;

    assign accept   = in_valid && in_ready;
    assign good_acc = accept && !bad;
    assign bad_acc  = accept && bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        unique case (1'b1)
            good_acc:                   state_d = HOLD;
            holding && !(done || tmo):  state_d = HOLD;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = '0;
        in_ready  = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            HOLD: begin
                out_valid = sel_q;
                in_ready  = done || tmo;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            data_q   <= '0;
            sel_q    <= '0;
            wait_cnt <= '0;
        end else begin
            if (good_acc) begin
                addr_q <= ingress_pkt_field;
                data_q <= in_data;
                sel_q  <= decoded_binary;
            end
            if (good_acc) begin
                wait_cnt <= '0;
            end else if (holding && !done && wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse_q <= 1'b0;
            tmo_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            err_pulse_q <= bad_acc;
            tmo_pulse_q <= tmo;
            if (bad_acc && err_cnt_q != CNT_MAX) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
            if (tmo && tmo_cnt_q != CNT_MAX) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    assign out_addr      = addr_q;
    assign out_data      = data_q;
    assign err_pulse     = err_pulse_q;
    assign timeout_pulse = tmo_pulse_q;
    assign err_cnt       = err_cnt_q;
    assign timeout_cnt   = tmo_cnt_q;

endmodule

// File: tb/tb_ah_client_dispatch_24.sv
// tb_ah_client_dispatch_24: vector table, corner sequences and
// randomized traffic against a packet-level reference model.
module tb_ah_client_dispatch_24;

    localparam int NC   = 4;
    localparam int AW   = 24;
    localparam int DW   = 32;
    localparam int TMO  = 4;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] ingress_pkt_field;
    logic [DW-1:0] in_data;
    logic [NC-1:0] decoded_binary;
    logic          dec_err;
    logic [NC-1:0] out_valid;
    logic [NC-1:0] out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          err_pulse;
    logic          timeout_pulse;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] timeout_cnt;

    int vectors;
    int miscompares;

    ah_client_dispatch_24 #(
        .NUM_CLIENTS(NC),
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT(TMO),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ingress_pkt_field(ingress_pkt_field),
        .in_data(in_data),
        .decoded_binary(decoded_binary),
        .dec_err(dec_err),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr(out_addr),
        .out_data(out_data),
        .err_pulse(err_pulse),
        .timeout_pulse(timeout_pulse),
        .err_cnt(err_cnt),
        .timeout_cnt(timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [NC-1:0] s;
        logic          e;
        logic [NC-1:0] r;
        logic [NC-1:0] xov;
        logic          xir;
        logic [AW-1:0] xa;
        logic [DW-1:0] xd;
        logic          xep;
        logic          xtp;
        logic [CW-1:0] xec;
        logic [CW-1:0] xtc;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [NC-1:0] s,
                          input logic e, input logic [NC-1:0] r);
        in_valid          = v;
        ingress_pkt_field = a;
        in_data           = d;
        decoded_binary    = s;
        dec_err           = e;
        out_ready         = r;
    endtask

    task automatic idle_in(input logic [NC-1:0] r);
        set_in(1'b0, '0, '0, '0, 1'b0, r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model: one optional held packet plus its age in cycles
    bit            m_held;
    logic [NC-1:0] m_sel;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_age;
    bit            m_ep;
    bit            m_tp;
    int            m_ec;
    int            m_tc;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        idle_in('0);
        repeat (3) tick();
        rst = 1'b0;

        tbl[0]  = '{0, 24'h0, 32'h0, 4'h0, 0, 4'h0,
                    4'h0, 1, 24'h0, 32'h0, 0, 0, 0, 0};
        tbl[1]  = '{1, 24'h001000, 32'hA5A50001, 4'h1, 0, 4'h1,
                    4'h0, 1, 24'h0, 32'h0, 0, 0, 0, 0};
        tbl[2]  = '{0, 24'h0, 32'h0, 4'h0, 0, 4'h1,
                    4'h1, 1, 24'h001000, 32'hA5A50001, 0, 0, 0, 0};
        tbl[3]  = '{0, 24'h0, 32'h0, 4'h0, 0, 4'h0,
                    4'h0, 1, 24'h001000, 32'hA5A50001, 0, 0, 0, 0};
        tbl[4]  = '{1, 24'h0F0F0F, 32'h11111111, 4'h1, 1, 4'h0,
                    4'h0, 1, 24'h001000, 32'hA5A50001, 0, 0, 0, 0};
        tbl[5]  = '{1, 24'h0F0F0F, 32'h22222222, 4'h6, 0, 4'h0,
                    4'h0, 1, 24'h001000, 32'hA5A50001, 1, 0, 1, 0};
        tbl[6]  = '{0, 24'h0, 32'h0, 4'h0, 0, 4'h0,
                    4'h0, 1, 24'h001000, 32'hA5A50001, 1, 0, 2, 0};
        tbl[7]  = '{0, 24'h0, 32'h0, 4'h0, 0, 4'h0,
                    4'h0, 1, 24'h001000, 32'hA5A50001, 0, 0, 2, 0};
        tbl[8]  = '{1, 24'h0F0F0F, 32'h44444444, 4'h0, 0, 4'h0,
                    4'h0, 1, 24'h001000, 32'hA5A50001, 0, 0, 2, 0};
        tbl[9]  = '{0, 24'h0, 32'h0, 4'h0, 0, 4'h0,
                    4'h0, 1, 24'h001000, 32'hA5A50001, 1, 0, 3, 0};
        tbl[10] = '{0, 24'h0, 32'h0, 4'h0, 0, 4'h0,
                    4'h0, 1, 24'h001000, 32'hA5A50001, 0, 0, 3, 0};
        tbl[11] = '{1, 24'h00ABCD, 32'h33333333, 4'h2, 0, 4'h0,
                    4'h0, 1, 24'h001000, 32'hA5A50001, 0, 0, 3, 0};
        tbl[12] = '{0, 24'h0, 32'h0, 4'h0, 0, 4'h0,
                    4'h2, 0, 24'h00ABCD, 32'h33333333, 0, 0, 3, 0};
        tbl[13] = '{0, 24'h0, 32'h0, 4'h0, 0, 4'hD,
                    4'h2, 0, 24'h00ABCD, 32'h33333333, 0, 0, 3, 0};
        tbl[14] = '{0, 24'h0, 32'h0, 4'h0, 0, 4'h0,
                    4'h2, 0, 24'h00ABCD, 32'h33333333, 0, 0, 3, 0};
        tbl[15] = '{0, 24'h0, 32'h0, 4'h0, 0, 4'h0,
                    4'h2, 0, 24'h00ABCD, 32'h33333333, 0, 0, 3, 0};
        tbl[16] = '{0, 24'h0, 32'h0, 4'h0, 0, 4'h0,
                    4'h2, 1, 24'h00ABCD, 32'h33333333, 0, 0, 3, 0};
        tbl[17] = '{0, 24'h0, 32'h0, 4'h0, 0, 4'h0,
                    4'h0, 1, 24'h00ABCD, 32'h33333333, 0, 1, 3, 1};
        tbl[18] = '{0, 24'h0, 32'h0, 4'h0, 0, 4'h0,
                    4'h0, 1, 24'h00ABCD, 32'h33333333, 0, 0, 3, 1};

        for (int i = 0; i < 19; i++) begin
            set_in(tbl[i].iv, tbl[i].a, tbl[i].d, tbl[i].s,
                   tbl[i].e, tbl[i].r);
            #4;
            chk($sformatf("tbl%0d out_valid", i), 64'(out_valid),
                64'(tbl[i].xov));
            chk($sformatf("tbl%0d in_ready", i), 64'(in_ready),
                64'(tbl[i].xir));
            chk($sformatf("tbl%0d out_addr", i), 64'(out_addr),
                64'(tbl[i].xa));
            chk($sformatf("tbl%0d out_data", i), 64'(out_data),
                64'(tbl[i].xd));
            chk($sformatf("tbl%0d err_pulse", i), 64'(err_pulse),
                64'(tbl[i].xep));
            chk($sformatf("tbl%0d timeout_pulse", i), 64'(timeout_pulse),
                64'(tbl[i].xtp));
            chk($sformatf("tbl%0d err_cnt", i), 64'(err_cnt),
                64'(tbl[i].xec));
            chk($sformatf("tbl%0d timeout_cnt", i), 64'(timeout_cnt),
                64'(tbl[i].xtc));
            tick();
        end

        // ready rises in the last HOLD cycle before the timeout
        set_in(1'b1, 24'h00BEEF, 32'h55555555, 4'h2, 1'b0, 4'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            idle_in((i == 4) ? 4'h2 : 4'h0);
            #4;
            chk($sformatf("late hold%0d out_valid", i), 64'(out_valid),
                64'(4'h2));
            chk($sformatf("late hold%0d in_ready", i), 64'(in_ready),
                64'(i == 4));
            tick();
        end
        idle_in('0);
        #4;
        chk("late out_valid", 64'(out_valid), 64'(0));
        chk("late timeout_pulse", 64'(timeout_pulse), 64'(0));
        chk("late timeout_cnt", 64'(timeout_cnt), 64'(1));
        tick();

        // back-to-back to client 2
        for (int i = 0; i <= 9; i++) begin
            if (i < 8)
                set_in(1'b1, 24'(24'h200000 + i), 32'hB0B00000 + 32'(i),
                       4'h4, 1'b0, 4'h4);
            else
                idle_in(4'h4);
            #4;
            if (i >= 1 && i <= 8) begin
                chk($sformatf("b2b%0d out_valid", i), 64'(out_valid),
                    64'(4'h4));
                chk($sformatf("b2b%0d out_data", i), 64'(out_data),
                    64'(32'hB0B00000 + 32'(i - 1)));
                chk($sformatf("b2b%0d out_addr", i), 64'(out_addr),
                    64'(24'h200000 + i - 1));
            end
            if (i == 9)
                chk("b2b tail out_valid", 64'(out_valid), 64'(0));
            chk($sformatf("b2b%0d in_ready", i), 64'(in_ready), 64'(1));
            tick();
        end

        // reset mid-HOLD discards the packet and clears counters
        set_in(1'b1, 24'h00C0DE, 32'h66666666, 4'h1, 1'b0, 4'h0);
        tick();
        idle_in('0);
        tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #4;
        chk("rst out_valid", 64'(out_valid), 64'(0));
        chk("rst in_ready", 64'(in_ready), 64'(1));
        chk("rst out_addr", 64'(out_addr), 64'(0));
        chk("rst out_data", 64'(out_data), 64'(0));
        chk("rst err_pulse", 64'(err_pulse), 64'(0));
        chk("rst timeout_pulse", 64'(timeout_pulse), 64'(0));
        chk("rst err_cnt", 64'(err_cnt), 64'(0));
        chk("rst timeout_cnt", 64'(timeout_cnt), 64'(0));
        tick();

        // five bad packets saturate a 2-bit counter
        for (int i = 0; i <= 6; i++) begin
            if (i < 5)
                set_in(1'b1, 24'h0, 32'h0, 4'h8, 1'b1, 4'h0);
            else
                idle_in('0);
            #4;
            chk($sformatf("sat%0d err_cnt", i), 64'(err_cnt),
                64'((i < 3) ? i : 3));
            chk($sformatf("sat%0d out_valid", i), 64'(out_valid), 64'(0));
            tick();
        end

        rst = 1'b1;
        idle_in('0);
        tick();
        rst = 1'b0;
        m_held = 0;
        m_sel  = '0;
        m_addr = '0;
        m_data = '0;
        m_age  = 0;
        m_ep   = 0;
        m_tp   = 0;
        m_ec   = 0;
        m_tc   = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [NC-1:0] s;
            logic [NC-1:0] r;
            bit            dlv;
            bit            tmd;
            bit            xir;
            bit            acc;
            bit            badp;
            if ($urandom_range(0, 7) < 6)
                s = NC'(1) << $urandom_range(0, NC - 1);
            else
                s = NC'($urandom);
            r = NC'($urandom);
            if ((cyc / 64) % 2 == 1)
                r = r & NC'($urandom) & NC'($urandom);
            set_in(1'($urandom_range(0, 2) != 0), AW'($urandom),
                   DW'($urandom), s, 1'($urandom_range(0, 9) == 0), r);
            #4;
            dlv = m_held && ((m_sel & out_ready) != '0);
            tmd = m_held && !dlv && (m_age == TMO);
            xir = !m_held || dlv || tmd;
            chk("rnd out_valid", 64'(out_valid),
                64'(m_held ? m_sel : 4'h0));
            chk("rnd in_ready", 64'(in_ready), 64'(xir));
            chk("rnd out_addr", 64'(out_addr), 64'(m_addr));
            chk("rnd out_data", 64'(out_data), 64'(m_data));
            chk("rnd err_pulse", 64'(err_pulse), 64'(m_ep));
            chk("rnd timeout_pulse", 64'(timeout_pulse), 64'(m_tp));
            chk("rnd err_cnt", 64'(err_cnt), 64'(m_ec));
            chk("rnd timeout_cnt", 64'(timeout_cnt), 64'(m_tc));

            acc  = in_valid && xir;
            badp = dec_err || ($countones(decoded_binary) != 1);
            m_ep = acc && badp;
            m_tp = tmd;
            if (m_ep && m_ec < CMAX) m_ec++;
            if (m_tp && m_tc < CMAX) m_tc++;
            if (m_held && (dlv || tmd)) m_held = 0;
            else if (m_held) m_age++;
            if (acc && !badp) begin
                m_held = 1;
                m_sel  = decoded_binary;
                m_addr = ingress_pkt_field;
                m_data = in_data;
                m_age  = 0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ah_client_dispatch_24.md
# ah_client_dispatch_24

Registered dispatch stage downstream of the 24-bit address decoder. Accepts one packet per handshake (address, payload, and the decoder's one-hot client select and error flag), and holds it in a single output register. The register presents the packet to exactly one client port with valid/ready flow control. Decode errors, multi-hot selects and client stalls longer than a programmable limit are dropped and counted.

## Interface
- NUM_CLIENTS, 4, number of client ports; equals the decoder's select width
- ADDR_W, 24, address field width
- DATA_W, 32, payload width
- TIMEOUT, 255, max cycles a held packet waits for its client; 0 disables the timeout
- CNT_W, 16, width of the saturating error counters

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream packet valid
- in_ready  output  1  stage can accept this cycle
- ingress_pkt_field  input  ADDR_W  packet address; also drives the decoder
- in_data  input  DATA_W  packet payload
- decoded_binary  input  NUM_CLIENTS  one-hot client select from the decoder
- dec_err  input  1  decoder no-hit flag
- out_valid  output  NUM_CLIENTS  per-client valid; at most one bit set
- out_ready  input  NUM_CLIENTS  per-client ready
- out_addr  output  ADDR_W  held address, shared by all clients
- out_data  output  DATA_W  held payload, shared by all clients
- err_pulse  output  1  one-cycle pulse: packet dropped for a decode error or multi-hot select
- timeout_pulse  output  1  one-cycle pulse: held packet dropped by timeout
- err_cnt  output  CNT_W  saturating count of decode drops
- timeout_cnt  output  CNT_W  saturating count of timeout drops

## Operation
- **FSM states:**
  - IDLE: register empty.
  - HOLD: register full, waiting on the selected client.
- **Accept:** occurs when in_valid && in_ready.
- **in_ready:** 1 in IDLE. In HOLD it equals `done || tmo`, which gives back-to-back throughput. in_ready has a combinational path from out_ready.
  - done = |(out_valid & out_ready)
  - tmo = timeout fires this cycle (see below)
- **Bad packet:** dec_err == 1, decoded_binary == 0, or more than one bit of decoded_binary set.
  - On accept of a bad packet: not stored, err_pulse = 1 next cycle, err_cnt += 1 (saturates at all-ones).
  - Next state: IDLE, unless the stage was in HOLD and the held packet is still not done/tmo (cannot occur, because in_ready gates it).
- **Good packet accept:** latch ingress_pkt_field, in_data and decoded_binary into sel_q. State → HOLD. wait_cnt clears to 0.
- **out_valid:** sel_q when in HOLD, else 0. out_addr and out_data hold their last latched values in IDLE.
- **Leaving HOLD on done:**
  - Without a same-cycle good accept: state → IDLE.
  - With a same-cycle good accept: reload and stay in HOLD.
  - With a same-cycle bad accept: state → IDLE and err_pulse.
- **wait_cnt:** increments each HOLD cycle without done. Saturates at TIMEOUT.
- **Timeout:** when TIMEOUT != 0, wait_cnt == TIMEOUT and !done, then tmo = 1.
  - Packet dropped, state → IDLE (or reload on a same-cycle accept).
  - timeout_pulse = 1 next cycle; timeout_cnt += 1 (saturating).
- **Priority:** done beats tmo in the same cycle; such a packet counts as delivered, not timed out.
- **Ready only:** out_ready on unselected ports is ignored.
- **Reset:** rst overrides everything. A held packet is discarded without counting.

## Timing
- **Reset values:** state IDLE, out_valid 0, out_addr 0, out_data 0, sel_q 0, wait_cnt 0, err_pulse 0, timeout_pulse 0, err_cnt 0, timeout_cnt 0. in_ready reads 1 the first cycle after reset deasserts.
- **Latency:** accept at edge N → out_valid visible from cycle N+1.
- **Throughput:** 1 packet/cycle when the selected client holds out_ready = 1.
- **Handshake:** out_valid, out_addr and out_data stay stable while out_valid && !out_ready. They change only on done, tmo, or rst.
- **Timeout window:** a packet held with no ready is dropped at the edge that ends its (TIMEOUT+1)-th HOLD cycle.
- **Pulses:** err_pulse and timeout_pulse are registered, high exactly one cycle after the causing edge. Both may be high in the same cycle.
- **Saturation:** err_cnt and timeout_cnt stop at 2^CNT_W−1 and never wrap.

## Test plan
- **Reset:** rst held 3 cycles mid-HOLD → all outputs 0, in_ready = 1 after release, counters stay 0.
- **Single delivery:** addr 0x001000, sel 4'b0001, out_ready = 4'b0001 → out_valid[0] high for exactly one cycle, one cycle after accept, out_data matches.
- **Back-to-back:** 8 packets to client 2 with out_ready[2] held high → 8 consecutive out_valid cycles, no bubble, in_ready stays 1.
- **Bad packets:** dec_err = 1, then sel 4'b0110 → no out_valid, err_pulse twice, err_cnt = 2.
- **Timeout, TIMEOUT = 4:** client 1 ready low → packet dropped after 5 HOLD cycles, timeout_pulse once, timeout_cnt = 1. Repeat with out_ready[1] rising exactly in the 5th HOLD cycle → delivered, timeout_cnt unchanged.
- **Saturation, CNT_W = 2:** 5 bad packets → err_cnt reads 3 and remains 3.
